alu_banked: RTL and testbench
=============================

Name: alu_banked

Overview:
Parametrised successor to the single-accumulator 8-bit ALU.
- Holds NREGS independent accumulators of WIDTH bits; each instruction selects one.
- Adds a ready handshake, multi-bit shifts executed iteratively, zero/carry flags and a sticky error state.
- Sits between the instruction sequencer and downstream consumers, which read the selected accumulator on result.

Parameters:
WIDTH, 8, accumulator and immediate width (>=2)
NREGS, 4, number of accumulators (power of two, >=2)
RB, log2(NREGS) (localparam, derived), width of the register-select field

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
inst  input  4+RB+WIDTH  {opcode[3:0], reg[RB-1:0], imm[WIDTH-1:0]}
inst_en  input  1  instruction valid
inst_ready  output  1  block can accept an instruction this cycle
result  output  WIDTH  accumulator selected by the last accepted instruction
flag_zero  output  1  last written value == 0
flag_carry  output  1  carry/borrow/shifted-out bit of the last write
error  output  1  sticky error indicator

Behaviour:
- One clock; reset synchronous, active-high. On reset: all accumulators 0, sel=0, flags 0, state RESET. Outputs: result=0, inst_ready=0, error=0.
- States:
  - RESET -> READY unconditionally after 1 cycle.
  - READY: inst_ready=1.
  - SHIFT: inst_ready=0.
  - ERROR: sticky, left only by reset.
- Handshake: accept when inst_en && inst_ready. inst_en while inst_ready=0 is ignored, not buffered.
- Acceptance sets sel=reg. The target accumulator A[reg] and result update on the next edge, so latency is 1 cycle for all non-shift ops.
- Opcodes:
  - 0 NOP: no write, flags unchanged.
  - 1 LDI: A=imm.
  - 2 ADD: A=A+imm, carry=carry-out.
  - 3 SUB: A=A-imm, carry=borrow (A<imm).
  - 4 NOT: A=~A.
  - 5 AND, 6 IOR, 7 XOR: bitwise with imm.
  - 8 SHL, 9 SHR: shift amount k=imm, logical, zero-fill.
  - A EQL, B NEQ, C LTS, D LTE, E GTS, F GTE: unsigned compare; A=1 or 0, zero-extended to WIDTH.
- Flags:
  - flag_zero is recomputed on every accumulator write.
  - flag_carry is cleared by LDI, NOT, bitwise and compare ops.
  - NOP leaves both flags unchanged.
- Shifts:
  - k=0: behaves as a 1-cycle write of the unchanged value; carry=0.
  - 1<=k<WIDTH: enter SHIFT; shift A[sel] by one bit per cycle for exactly k cycles, then return to READY. inst_ready rises k cycles after acceptance. carry=last bit shifted out. result shows intermediate values.
  - k>=WIDTH: enter ERROR.
- ERROR: result=0, flags 0, inst_ready=0, error=1. Accumulators are not observable.
- Reset mid-SHIFT aborts the shift; all accumulators clear.
- Arithmetic wraps modulo 2^WIDTH unless ALU_BANKED_SATURATE_EN is defined.

Optional Feature:
ALU_BANKED_SATURATE_EN
- Defined: ADD clamps to 2^WIDTH-1 and SUB clamps to 0. carry is still set when a clamp occurs.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.
- Shift and compare behaviour is identical in both builds.

Decomposition:
- Shared package alu_banked_pkg holds:
  - the opcode constants (4'h0..4'hF);
  - state encodings RESET/READY/SHIFT/ERROR;
  - a function computing RB from NREGS.
- One sub-module, alu_banked_exec: combinational, single-cycle datapath for non-shift ops. Takes (op, a, imm) and returns (value, carry); parameterised by WIDTH; contains the saturation option.
- Top level owns the register bank, the FSM and the shift counter.

Test Plan (WIDTH=8, NREGS=4):
- Reset, then LDI r2 0x0F; read r2 -> inst_ready high 1 cycle after reset release; result=0x0F and flag_zero=0 one cycle after acceptance.
- LDI r0 0xF0; ADD r0 0x20 -> wrap build: result=0x10, carry=1. Saturate build: result=0xFF, carry=1.
- LDI r1 0x81; SHL r1 3 -> inst_ready low exactly 3 cycles; result sequence 0x02, 0x04, 0x08; carry=0 (last bit shifted out). r0 unchanged.
- SUB r3 0x01 from reset value 0 -> wrap build: result=0xFF, carry=1. Saturate build: result=0x00, zero=1, carry=1.
- SHR r0 8 -> error=1, result=0, inst_ready=0 permanently. Then reset -> RESET then READY, all accumulators 0.
- During a SHL r1 5, assert inst_en with LDI r1 0x55 while busy -> ignored, shift completes. Assert reset mid-shift -> next cycle result=0, state RESET.

Source files
------------

// File: rtl/alu_banked_pkg.sv
// Shared definitions for the banked accumulator ALU: opcodes, FSM states and
// the register-select width helper.
package alu_banked_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_IOR = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_EQL = 4'hA;
  localparam logic [3:0] OP_NEQ = 4'hB;
  localparam logic [3:0] OP_LTS = 4'hC;
  localparam logic [3:0] OP_LTE = 4'hD;
  localparam logic [3:0] OP_GTS = 4'hE;
  localparam logic [3:0] OP_GTE = 4'hF;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    READY = 2'd1,
    SHIFT = 2'd2,
    ERROR = 2'd3
  } state_e;

  // Smallest rb with 2**rb >= nregs.
  function automatic int calc_rb(input int nregs);
    int rb;
    rb = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < nregs) rb = i + 1;
    end
    return rb;
  endfunction

endpackage

// File: rtl/alu_banked_exec.sv
// Single-cycle combinational datapath for all non-shift opcodes.
// ALU_BANKED_SATURATE_EN: ADD/SUB clamp instead of wrapping (carry still set).
module alu_banked_exec
  import alu_banked_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, imm};
  assign diff = {1'b0, a} - {1'b0, imm};

  // Shift opcodes fall into the default arm: a zero-length shift rewrites a unchanged.
  always_comb begin
    value = a;
    carry = 1'b0;
    case (op)
      OP_LDI: value = imm;
      OP_ADD: begin
        carry = sum[WIDTH];
`ifdef ALU_BANKED_SATURATE_EN
        value = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        value = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        carry = diff[WIDTH];
`ifdef ALU_BANKED_SATURATE_EN
        value = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        value = diff[WIDTH-1:0];
`endif
      end
      OP_NOT: value = ~a;
      OP_AND: value = a & imm;
      OP_IOR: value = a | imm;
      OP_XOR: value = a ^ imm;
      OP_EQL: value = WIDTH'(a == imm);
      OP_NEQ: value = WIDTH'(a != imm);
      OP_LTS: value = WIDTH'(a < imm);
      OP_LTE: value = WIDTH'(a <= imm);
      OP_GTS: value = WIDTH'(a > imm);
      OP_GTE: value = WIDTH'(a >= imm);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_banked.sv
// Banked accumulator ALU: NREGS accumulators, ready handshake, iterative shifts,
// zero/carry flags and sticky error. Optional macro: ALU_BANKED_SATURATE_EN.
module alu_banked
  import alu_banked_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int RB = calc_rb(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4+RB+WIDTH-1:0] inst,
  input  logic                  inst_en,
  output logic                  inst_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  error
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  logic [3:0]       op;
  logic [RB-1:0]    reg_idx;
  logic [WIDTH-1:0] imm;

  assign {op, reg_idx, imm} = inst;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q [NREGS];
  logic [WIDTH-1:0] acc_d [NREGS];
  logic [RB-1:0]    sel_q, sel_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;

  logic [WIDTH-1:0] exec_value;
  logic             exec_carry;
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH-1:0] shifted;
  logic             shift_out;
  logic             is_shift;

  alu_banked_exec #(.WIDTH(WIDTH)) u_exec (
    .op    (op),
    .a     (acc_q[reg_idx]),
    .imm   (imm),
    .value (exec_value),
    .carry (exec_carry)
  );

  assign is_shift  = (op == OP_SHL) || (op == OP_SHR);
  assign shift_src = acc_q[sel_q];
  assign shifted   = left_q ? {shift_src[WIDTH-2:0], 1'b0} : {1'b0, shift_src[WIDTH-1:1]};
  assign shift_out = left_q ? shift_src[WIDTH-1] : shift_src[0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    case (state_q)
      RESET: state_d = READY;
      READY: begin
        if (inst_en) begin
          sel_d = reg_idx;
          if (is_shift && (imm >= WIDTH_V)) begin
            state_d = ERROR;
          end else if (is_shift && (imm != '0)) begin
            state_d = SHIFT;
            cnt_d   = imm;
            left_d  = (op == OP_SHL);
          end else if (op != OP_NOP) begin
            acc_d[reg_idx] = exec_value;
            zero_d         = (exec_value == '0);
            carry_d        = exec_carry;
          end
        end
      end
      // One bit per cycle; the remaining count reaching one means this is the last step.
      SHIFT: begin
        acc_d[sel_q] = shifted;
        zero_d       = (shifted == '0);
        carry_d      = shift_out;
        cnt_d        = cnt_q - ONE_V;
        if (cnt_q == ONE_V) state_d = READY;
      end
      ERROR: ;
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET;
      sel_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      acc_q   <= acc_d;
    end
  end

  assign inst_ready = (state_q == READY);
  assign error      = (state_q == ERROR);
  assign result     = error ? '0 : acc_q[sel_q];
  assign flag_zero  = error ? 1'b0 : zero_q;
  assign flag_carry = error ? 1'b0 : carry_q;

endmodule

// File: tb/tb_alu_banked.sv
// Scoreboard bench for alu_banked (WIDTH=8, NREGS=4): a cycle-level reference
// model pushes expected outputs, a negedge monitor pops and compares them.
module tb_alu_banked;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int MASK = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] inst = '0;
  logic        inst_en = 1'b0;
  logic        inst_ready;
  logic [7:0]  result;
  logic        flag_zero, flag_carry, error;

  alu_banked #(.WIDTH(W), .NREGS(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .inst       (inst),
    .inst_en    (inst_en),
    .inst_ready (inst_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int res;
    bit z;
    bit c;
    bit rdy;
    bit err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;

  // Reference model: architectural state visible after each clock edge.
  int m_acc[N];
  int m_sel = 0;
  bit m_z = 0, m_c = 0, m_err = 0, m_inrst = 1;
  int m_busy = 0, m_step = 0, m_orig = 0;
  bit m_left = 0;

  function automatic bit model_ready();
    return !m_inrst && !m_err && (m_busy == 0);
  endfunction

  task automatic model_step(input bit rst, input bit en, input int op, input int r, input int imm);
    int a, v;
    bit wr;
    if (rst) begin
      foreach (m_acc[i]) m_acc[i] = 0;
      m_sel = 0; m_z = 0; m_c = 0; m_err = 0; m_inrst = 1; m_busy = 0;
      return;
    end
    if (m_err) return;
    if (m_inrst) begin
      m_inrst = 0;
      return;
    end
    if (m_busy > 0) begin
      m_step++;
      m_busy--;
      if (m_left) begin
        m_acc[m_sel] = (m_orig << m_step) & MASK;
        m_c = (m_orig >> (W - m_step)) & 1;
      end else begin
        m_acc[m_sel] = m_orig >> m_step;
        m_c = (m_orig >> (m_step - 1)) & 1;
      end
      m_z = (m_acc[m_sel] == 0);
      return;
    end
    if (!en) return;
    m_sel = r;
    a = m_acc[r];
    v = a;
    wr = 1;
    case (op)
      0: wr = 0;
      1: begin v = imm; m_c = 0; end
      2: begin
        v = a + imm;
        m_c = (v > MASK);
`ifdef ALU_BANKED_SATURATE_EN
        v = m_c ? MASK : v;
`else
        v = v & MASK;
`endif
      end
      3: begin
        m_c = (a < imm);
`ifdef ALU_BANKED_SATURATE_EN
        v = m_c ? 0 : a - imm;
`else
        v = (a - imm) & MASK;
`endif
      end
      4: begin v = ~a & MASK; m_c = 0; end
      5: begin v = a & imm; m_c = 0; end
      6: begin v = a | imm; m_c = 0; end
      7: begin v = a ^ imm; m_c = 0; end
      8, 9: begin
        if (imm == 0) begin
          m_c = 0;
        end else if (imm >= W) begin
          m_err = 1; wr = 0;
        end else begin
          m_busy = imm; m_step = 0; m_orig = a; m_left = (op == 8); wr = 0;
        end
      end
      10: begin v = (a == imm) ? 1 : 0; m_c = 0; end
      11: begin v = (a != imm) ? 1 : 0; m_c = 0; end
      12: begin v = (a <  imm) ? 1 : 0; m_c = 0; end
      13: begin v = (a <= imm) ? 1 : 0; m_c = 0; end
      14: begin v = (a >  imm) ? 1 : 0; m_c = 0; end
      default: begin v = (a >= imm) ? 1 : 0; m_c = 0; end
    endcase
    if (wr) begin
      m_acc[r] = v;
      m_z = (v == 0);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.err = m_err;
    e.rdy = model_ready();
    e.res = m_err ? 0 : m_acc[m_sel];
    e.z   = m_err ? 1'b0 : m_z;
    e.c   = m_err ? 1'b0 : m_c;
    e.cyc = cyc_n;
    return e;
  endfunction

  // Drive one cycle of inputs, record the expected post-edge outputs, advance.
  task automatic step(input bit rst, input bit en, input int op, input int r, input int imm);
    if (!rst && en && model_ready())
      $display("INS cyc=%0d op=%h r=%0d imm=%02h", cyc_n, op[3:0], r, imm[7:0]);
    reset   = rst;
    inst_en = en;
    inst    = {4'(op), 2'(r), 8'(imm)};
    model_step(rst, en, op, r, imm);
    sb.push_back(model_expect());
    @(posedge clock);
    cyc_n++;
    @(negedge clock);
    #1;
  endtask

  function automatic void chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", e.cyc, 32'(result), 32'(e.res));
      chk("flag_zero", e.cyc, 32'(flag_zero), 32'(e.z));
      chk("flag_carry", e.cyc, 32'(flag_carry), 32'(e.c));
      chk("inst_ready", e.cyc, 32'(inst_ready), 32'(e.rdy));
      chk("error", e.cyc, 32'(error), 32'(e.err));
    end
  end

  initial begin
    bit rst, en;
    int op, r, imm;
    @(negedge clock);
    #1;
    // Directed sequence following the bring-up scenarios.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 2, 'h0F);
    step(0, 1, 1, 2, 'h0F);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 'hF0);
    step(0, 1, 2, 0, 'h20);
    step(0, 1, 1, 1, 'h81);
    step(0, 1, 8, 1, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 3, 3, 'h01);
    step(0, 1, 0, 0, 0);
    step(0, 1, 9, 0, 8);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 'h33);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 'h0B);
    step(0, 1, 8, 1, 5);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 'h55);
    step(0, 1, 8, 1, 5);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);

    // Randomized phase.
    for (int n = 0; n < 1500; n++) begin
      rst = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) < 7);
      op  = $urandom_range(0, 15);
      r   = $urandom_range(0, 3);
      if (op == 8 || op == 9) begin
        imm = ($urandom_range(0, 19) == 0) ? $urandom_range(8, 255) : $urandom_range(0, 7);
      end else begin
        imm = $urandom_range(0, 255);
        if ($urandom_range(0, 4) == 0) imm = $urandom_range(0, 1) ? 0 : MASK;
        if (op >= 10 && $urandom_range(0, 2) == 0) imm = m_acc[r];
      end
      step(rst, en, op, r, imm);
    end

    chk("scoreboard_drained", cyc_n, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
